// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration writer and its bank.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DRAIN  = 2'd3
    } cfg_state_e;

    localparam int DEF_LUT_INPUTS = 4;
    localparam int DEF_MEM_SIZE   = 1 << DEF_LUT_INPUTS;

    function automatic int mem_size(input int lut_inputs);
        return 1 << lut_inputs;
    endfunction

    function automatic int words(input int num_luts, input int lut_inputs, input int word_w);
        return (num_luts * mem_size(lut_inputs)) / word_w;
    endfunction

    // A counter for a single-word frame still needs one bit.
    function automatic int cnt_width(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

endpackage

// File: rtl/lut_cfg_bank.sv
// Shadow image written word by word and the active image it is copied into on commit.
module lut_cfg_bank
    import lut_cfg_pkg::*;
#(
    parameter int TOTAL_W = 128,
    parameter int WORD_W  = 8,
    parameter int WORDS   = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [WORD_W-1:0]  wr_data_i,
    input  logic               commit_i,
    output logic [TOTAL_W-1:0] lut_mem_o
);

    logic [TOTAL_W-1:0] shadow_q;
    logic [TOTAL_W-1:0] shadow_d;
    logic [TOTAL_W-1:0] active_q;
    logic [TOTAL_W-1:0] active_d;

    // Next shadow: only in-range indices can be written.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < WORDS; k++) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(k))) begin
                shadow_d[k*WORD_W +: WORD_W] = wr_data_i;
            end else begin
                shadow_d[k*WORD_W +: WORD_W] = shadow_q[k*WORD_W +: WORD_W];
            end
        end
    end

    // Next active image: replaced wholesale on commit, otherwise held.
    always_comb begin
        active_d = active_q;
        if (commit_i) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
    end

    // Image registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            shadow_q <= {TOTAL_W{1'b0}};
            active_q <= {TOTAL_W{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign lut_mem_o = active_q;

endmodule

// File: rtl/lut_cfg_writer.sv
// Frames a word-serial configuration stream and commits well-formed images atomically
// to the active LUT memory; malformed frames are discarded with a one-cycle error pulse.
module lut_cfg_writer
    import lut_cfg_pkg::*;
#(
    parameter int LUT_INPUTS = 4,
    parameter int NUM_LUTS   = 8,
    parameter int WORD_W     = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [WORD_W-1:0]                        cfg_data,
    input  logic                                     cfg_last,
    output logic [NUM_LUTS*mem_size(LUT_INPUTS)-1:0] lut_mem,
    output logic                                     busy,
    output logic                                     cfg_done,
    output logic                                     cfg_err
);

    localparam int MEM_SIZE = mem_size(LUT_INPUTS);
    localparam int TOTAL_W  = NUM_LUTS * MEM_SIZE;
    localparam int WORDS    = words(NUM_LUTS, LUT_INPUTS, WORD_W);
    localparam int CNT_W    = cnt_width(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    if ((TOTAL_W % WORD_W) != 0) begin : g_bad_word_w
        $error("lut_cfg_writer: NUM_LUTS*MEM_SIZE must be a multiple of WORD_W");
    end

    cfg_state_e       state_q;
    cfg_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;
    logic             err_q;
    logic             err_d;
    logic             wr_en_s;
    logic             commit_s;
    logic             xfer_s;

    assign cfg_ready = (state_q != COMMIT);
    assign busy      = (state_q != IDLE);
    assign xfer_s    = cfg_valid && cfg_ready;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

    // Frame sequencing: next state, word counter, shadow write and commit strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en_s  = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    wr_en_s = 1'b1;
                    if (cfg_last && (WORDS > 1)) begin
                        err_d = 1'b1;
                        cnt_d = {CNT_W{1'b0}};
                    end else if (WORDS == 1) begin
                        state_d = cfg_last ? COMMIT : DRAIN;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (xfer_s) begin
                    wr_en_s = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = cfg_last ? COMMIT : DRAIN;
                    end else if (cfg_last) begin
                        err_d   = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                done_d   = 1'b1;
                cnt_d    = {CNT_W{1'b0}};
                state_d  = IDLE;
            end
            DRAIN: begin
                // Overlong frame: swallow words until its end, then report it.
                if (xfer_s && cfg_last) begin
                    err_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    lut_cfg_bank #(
        .TOTAL_W (TOTAL_W),
        .WORD_W  (WORD_W),
        .WORDS   (WORDS),
        .IDX_W   (CNT_W)
    ) u_bank (
        .clk       (clk),
        .clr_i     (rst),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (cnt_q),
        .wr_data_i (cfg_data),
        .commit_i  (commit_s),
        .lut_mem_o (lut_mem)
    );

endmodule

// File: doc/lut_cfg_writer.md
# lut_cfg_writer

Configuration writer for a bank of plain LUTs. Accepts a word-serial configuration stream over a valid/ready handshake and assembles it into a shadow image. On a correctly framed stream it commits the image atomically to the active LUT memory that drives the LUT `mem` contents. It sits between the fabric configuration port and the LUT/fractured-LUT tiles; malformed frames are discarded and never disturb the active image.

## Interface
Parameters:
- `LUT_INPUTS`, 4: address width per LUT. `MEM_SIZE = 2**LUT_INPUTS`.
- `NUM_LUTS`, 8: number of LUTs in the bank.
- `WORD_W`, 8: configuration word width. `NUM_LUTS*MEM_SIZE` must be a multiple of `WORD_W`. `WORDS = NUM_LUTS*MEM_SIZE/WORD_W`.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: synchronous active-high reset.
- `cfg_valid` input 1: a word is offered.
- `cfg_ready` output 1: the writer can accept a word.
- `cfg_data` input `WORD_W`: configuration word.
- `cfg_last` input 1: the offered word is the last of its frame.
- `lut_mem` output `NUM_LUTS*MEM_SIZE`: active image. LUT i occupies `[i*MEM_SIZE +: MEM_SIZE]`; bit a is that LUT's output for address a.
- `busy` output 1: a frame is in progress (state not IDLE).
- `cfg_done` output 1: one-cycle pulse when a new image is committed.
- `cfg_err` output 1: one-cycle pulse when a frame is discarded.

## Operation
- A transfer occurs in any cycle where `cfg_valid && cfg_ready`. There are no other side effects.
- Word k of a frame is written to shadow `[k*WORD_W +: WORD_W]`. The word counter is `$clog2(WORDS)` bits wide (minimum 1), starts at 0 and increments per transfer.
- States:
  - **IDLE**: `cfg_ready=1`. A transfer writes word 0. If it carries `cfg_last` and `WORDS>1`, go to IDLE with an error. Otherwise go to LOAD (or to COMMIT if `WORDS==1` and `cfg_last`).
  - **LOAD**: `cfg_ready=1`.
    - Transfer with index < `WORDS-1` and `cfg_last`: error, return to IDLE.
    - Index `WORDS-1` with `cfg_last`: go to COMMIT.
    - Index `WORDS-1` without `cfg_last`: go to DRAIN.
  - **COMMIT**: `cfg_ready=0` for exactly one cycle. `lut_mem <= shadow`, `cfg_done <= 1`, counter cleared, then go to IDLE.
  - **DRAIN**: `cfg_ready=1`. Words are accepted and discarded. A transfer with `cfg_last` raises an error and returns to IDLE.
- Error: `cfg_err <= 1` for one cycle and the counter is cleared. `lut_mem` is unchanged. Shadow contents are don't-care and are overwritten by the next frame.
- `cfg_done` and `cfg_err` are never asserted in the same cycle.
- Gaps in `cfg_valid` (valid low) hold all state. There is no timeout.
- `cfg_data` is ignored when no transfer occurs.

## Timing
- Reset values: `lut_mem=0`, shadow 0, counter 0, state IDLE, `cfg_ready=1`, `busy=0`, `cfg_done=0`, `cfg_err=0`.
- `cfg_ready` and `busy` are decoded from the registered state only. There is no combinational path from `cfg_valid` to `cfg_ready`.
- If the final word transfers in cycle N:
  - Cycle N+1: state COMMIT, `cfg_ready=0`.
  - Cycle N+2: new `lut_mem` and `cfg_done=1` are visible together. `cfg_ready=1`, so the next frame's word 0 can transfer in N+2.
- If an erroring transfer occurs in cycle N, `cfg_err=1` in cycle N+1 and `cfg_ready=1` in cycle N+1 (no dead cycle).
- Throughput is one word per cycle within a frame, plus one dead cycle per committed frame.
- Reset mid-frame or during COMMIT: everything returns to reset values on that edge, including `lut_mem=0`. A pending commit is lost.
- `rst` overrides every other event.

## Structure
- Shared package `lut_cfg_pkg`:
  - state enum `{IDLE, LOAD, COMMIT, DRAIN}`;
  - function `words(num_luts, lut_inputs, word_w)`;
  - localparam helpers for `MEM_SIZE`.
- One sub-module, `lut_cfg_bank`, holds the shadow and active registers. Its interface is word write-enable plus index plus data, a commit strobe, and a synchronous clear.
- The FSM, counter and handshake live in `lut_cfg_writer`.
- An elaboration-time check rejects `NUM_LUTS*MEM_SIZE % WORD_W != 0`.

## Test plan
Defaults throughout: 8 LUTs × 16 bits, `WORD_W=8`, so `WORDS=16`.
1. **Reset:** hold `rst` 2 cycles with `cfg_valid=1` → `lut_mem=0`, `cfg_ready=1`, `busy=0`, no pulses, no transfer counted.
2. **Full frame:** words 0x00..0x0F back-to-back, `cfg_last` on 0x0F →
   - COMMIT cycle has `cfg_ready=0`;
   - two cycles after the last transfer, `lut_mem[15:0]=0x0100` and `lut_mem[127:112]=0x0F0E`;
   - `cfg_done` high exactly one cycle.
3. **Early last:** load image A, then send 6 words with `cfg_last` on word 5 → `cfg_err` one cycle, `lut_mem` still A. A following good frame B commits B.
4. **Missing last:** 20 words with `cfg_last` only on word 19 → words 16..19 accepted in DRAIN, `cfg_err` once after word 19, `lut_mem` unchanged, no `cfg_done`.
5. **Back-to-back with valid gaps:** two frames with random `cfg_valid` gaps and `cfg_valid` held high through COMMIT → no transfer during COMMIT; frame 2 word 0 accepted in N+2; both images committed in order.
6. **Reset mid-frame:** assert `rst` after word 7 of a frame that follows a committed image → `lut_mem=0`, counter 0, no pulse. The next full frame commits correctly.
